// File: rtl/binary_to_gray_conv_pkg.sv
// Shared width, direction encoding and reference conversion functions for the
// 4-bit binary/Gray code converter.
package binary_to_gray_pkg;

  localparam int CODE_W = 4;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    DIR_B2G = 1'b0,
    DIR_G2B = 1'b1
  } dir_e;

  function automatic code_t bin2gray(input code_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB down: each binary bit is the parity of all
  // Gray bits at or above it.
  function automatic code_t gray2bin(input code_t gray);
    code_t bin;
    bin[CODE_W-1] = gray[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/binary_to_gray_conv_if.sv
// Request/response bundle for the code converter: a qualified 4-bit code with
// direction in, a one-cycle-valid 4-bit result out.
interface binary_to_gray_conv_if;
  import binary_to_gray_pkg::*;

  logic  in_valid;
  logic  dir;
  code_t b;
  code_t g;
  logic  out_valid;

  modport master (
    output in_valid, dir, b,
    input  g, out_valid
  );

  modport slave (
    input  in_valid, dir, b,
    output g, out_valid
  );

endinterface

// File: rtl/binary_to_gray_conv_core.sv
// Combinational XOR network converting a 4-bit code in either direction.
module binary_to_gray_core
  import binary_to_gray_pkg::*;
(
  input  code_t code,
  input  dir_e  dir,
  output code_t result
);

  // NOTE: result gets a value on every path through always_comb, so no latch
  // can be inferred even if a new direction is added later.
  always_comb begin
    result = '0;
    unique case (dir)
      DIR_B2G: result = bin2gray(code);
      DIR_G2B: result = gray2bin(code);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/binary_to_gray_conv.sv
// Registered binary<->Gray nibble converter: one-cycle latency, result held
// between accepted inputs, out_valid pulses once per accepted input.
module binary_to_gray_conv
  import binary_to_gray_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic dir,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic out_valid
);

  code_t in_code;
  code_t core_res;
  code_t res_q;
  logic  valid_q;

  assign in_code = {b3, b2, b1, b0};

  binary_to_gray_core u_core (
    .code   (in_code),
    .dir    (dir_e'(dir)),
    .result (core_res)
  );

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; reset wins over a simultaneous in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      // Only a qualified capture can change the result, so X on idle inputs
      // never reaches the outputs.
      if (in_valid) begin
        res_q <= core_res;
      end
    end
  end

  assign {g3, g2, g1, g0} = res_q;
  assign out_valid        = valid_q;

endmodule

// File: tb/tb_binary_to_gray_conv.sv
// Scoreboard bench for binary_to_gray_conv: directed vectors push expected
// results; a negedge monitor pops and compares on every out_valid.
module tb_binary_to_gray_conv;
  import binary_to_gray_pkg::*;

  typedef struct {
    logic [3:0] exp;
    bit         one_bit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  logic [3:0] last_g = 4'b0000;

  // Hand-computed reflected Gray codes for 0..15.
  logic [3:0] gray_tab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  binary_to_gray_conv_if bus ();
  wire [3:0] g_w;
  wire       ov_w;
  assign bus.g         = g_w;
  assign bus.out_valid = ov_w;

  binary_to_gray_conv dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .dir       (bus.dir),
    .b0        (bus.b[0]),
    .b1        (bus.b[1]),
    .b2        (bus.b[2]),
    .b3        (bus.b[3]),
    .g0        (g_w[0]),
    .g1        (g_w[1]),
    .g2        (g_w[2]),
    .g3        (g_w[3]),
    .out_valid (ov_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 4'd1, 4'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.g, e.exp);
        if (e.one_bit) begin
          check("gray_one_bit_step", 4'($countones(bus.g ^ last_g)), 4'd1);
        end
        last_g = bus.g;
      end
    end
  end

  task automatic send(input logic d, input logic [3:0] v, input logic [3:0] exp,
                      input bit one_bit);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.dir      = d;
    bus.b        = v;
    e.exp        = exp;
    e.one_bit    = one_bit;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dir      = 1'($urandom);
    bus.b        = 4'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.dir      = 1'b0;
    bus.b        = 4'b1111;

    // Reset held two edges while in_valid is high.
    @(posedge clk);
    @(negedge clk);
    check("reset_g_1", bus.g, 4'b0000);
    check("reset_ov_1", {3'b0, bus.out_valid}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("reset_g_2", bus.g, 4'b0000);
    check("reset_ov_2", {3'b0, bus.out_valid}, 4'b0000);

    // First edge after release captures b=1111.
    begin
      exp_t e;
      #1;
      rst       = 1'b0;
      e.exp     = 4'b1000;
      e.one_bit = 1'b0;
      exp_q.push_back(e);
    end

    // Ascending binary sweep, back-to-back.
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 4'(i), gray_tab[i], i != 0);
    end

    // Spot values in both directions, alternating dir each cycle.
    send(1'b0, 4'b0101, 4'b0111, 1'b0);
    send(1'b1, 4'b0111, 4'b0101, 1'b0);
    send(1'b0, 4'b1000, 4'b1100, 1'b0);
    send(1'b1, 4'b1000, 4'b1111, 1'b0);
    send(1'b0, 4'b1011, 4'b1110, 1'b0);
    send(1'b1, 4'b1110, 4'b1011, 1'b0);

    // Round trip: Gray->binary of every Gray code returns the original.
    for (int i = 0; i < 16; i++) begin
      send(1'b1, gray_tab[i], 4'(i), 1'b0);
    end

    // Hold: one accept, then five idle cycles with random inputs.
    send(1'b0, 4'b0011, 4'b0010, 1'b0);
    idle();
    for (int k = 0; k < 5; k++) begin
      idle();
      @(negedge clk);
      check("hold_g", bus.g, 4'b0010);
      check("hold_ov", {3'b0, bus.out_valid}, 4'b0000);
    end

    // Reset mid-stream discards the simultaneous input.
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.dir      = 1'b0;
    bus.b        = 4'b1111;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_g", bus.g, 4'b0000);
    check("midrst_ov", {3'b0, bus.out_valid}, 4'b0000);
    idle();
    @(negedge clk);
    check("post_rst_g", bus.g, 4'b0000);
    check("post_rst_ov", {3'b0, bus.out_valid}, 4'b0000);

    // First accept after reset behaves normally.
    send(1'b0, 4'b0110, 4'b0101, 1'b0);
    idle();
    idle();
    idle();
    @(negedge clk);
    check("scoreboard_drained", 4'(exp_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_to_gray_conv.md
Name: binary_to_gray_conv

Overview:
- Registered 4-bit code converter.
- Default direction converts a natural binary nibble to reflected Gray code.
- Also performs the inverse, Gray to binary, when dir is set.
- Sits on a single clock domain, between counter/pointer logic and consumers that need single-bit-change encodings (CDC pointers, encoders, display).

Parameters:
- none (width fixed at 4; shared constant CODE_W = 4 in package)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  capture strobe for b3..b0 / dir
- dir  input  1  0 = binary->Gray, 1 = Gray->binary
- b0  input  1  input bit 0 (LSB)
- b1  input  1  input bit 1
- b2  input  1  input bit 2
- b3  input  1  input bit 3 (MSB)
- g0  output  1  result bit 0 (LSB), registered
- g1  output  1  result bit 1, registered
- g2  output  1  result bit 2, registered
- g3  output  1  result bit 3 (MSB), registered
- out_valid  output  1  high for one cycle after each accepted input

Behaviour:
- Reset behaviour:
  - All state updates only on rising clk.
  - rst sampled high: g3..g0 <= 0000, out_valid <= 0.
  - rst has priority over in_valid on the same edge.
- dir=0 (binary->Gray):
  - g3=b3
  - g2=b3^b2
  - g1=b2^b1
  - g0=b1^b0
- dir=1 (Gray->binary, prefix XOR from MSB):
  - g3=b3
  - g2=b3^b2
  - g1=b3^b2^b1
  - g0=b3^b2^b1^b0
- Latency and handshake:
  - Latency exactly 1 cycle: inputs sampled on the edge where in_valid=1; result and out_valid=1 visible after that edge.
  - in_valid=0: g3..g0 hold their last value; out_valid <= 0.
  - Back-to-back in_valid accepted every cycle; no backpressure; no busy state.
- dir is sampled with data; changing dir between inputs has no side effect.
- Round-trip property: Gray->binary(binary->Gray(x)) = x for all 16 values.
- All 16 codes are legal in both directions; no error output.
- Reset mid-stream: any pending result is discarded; first accepted input after rst deasserts produces a normal 1-cycle result.
- X on inputs while in_valid=0 must not affect outputs.

Decomposition:
- Package binary_to_gray_pkg:
  - CODE_W = 4
  - pure functions bin2gray(4-bit) and gray2bin(4-bit)
- One combinational sub-module, binary_to_gray_core:
  - 4-bit in, dir, 4-bit out
  - pure XOR network implementing both directions
- Top module wraps the core with the in_valid-qualified output register and the out_valid flop.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, b=1111 -> g=0000, out_valid=0; first edge after rst=0 -> g=1000, out_valid=1.
- Binary sweep dir=0, in_valid=1 every cycle, b=0000..1111 ascending -> g = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, each one cycle later; consecutive outputs differ in exactly one bit.
- Spot values dir=0: b=0101 -> g=0111; b=1000 -> g=1100; b=1011 -> g=1110.
- Inverse dir=1: b=0111 -> g=0101; b=1000 -> g=1111; b=1110 -> g=1011. Full 16-value round trip through both directions returns the original value.
- Hold: accept b=0011 (g=0010), then in_valid=0 for 5 cycles while b toggles randomly -> g stays 0010, out_valid=0 throughout.
- Reset mid-stream: in_valid=1 b=1111, rst=1 on the same edge -> g=0000, out_valid=0; no stale 1000 appears afterwards.
